ram_spi_burst: RTL

Parametrised command-decoded RAM sitting behind the SPI slave: each received word carries a 2-bit command and a DATA_SIZE-bit payload. It is the successor to the single-word SPI RAM, adding:
- configurable data and address widths;
- write/read address auto-increment;
- multi-word burst reads with a tx_valid/tx_ready handshake;
- rx_ready back-pressure while a burst is in progress.

---
 rtl/ram_spi_burst.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ram_spi_burst.sv
// rtl/ram_spi_burst.sv - command-decoded RAM with burst reads behind an SPI slave
//
// Optional feature macro: RAM_SPI_AUTOINC_EN
//   defined   : write/read address auto-increment, burst length from command 11 payload
//   undefined : addresses change only via commands 00/10, command 11 reads one word
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears memory, addresses, FSM)
//   rx_valid  din holds a command word
//   rx_ready  command accepted this cycle when rx_valid is also high
//   din       [DATA_SIZE+1:DATA_SIZE] command, [DATA_SIZE-1:0] payload
//   tx_valid  dout holds a read word
//   tx_ready  consumer takes dout this cycle
//   dout      read data
//   cmd_err   sticky: a command arrived while rx_ready was low

module ram_spi_burst #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [DATA_SIZE+1:0] din,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 cmd_err
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_BURST = 2'b11;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state_q, state_d;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  // One bit wider than the address so a full-depth burst (2**ADDR_SIZE words) fits.
  logic [ADDR_SIZE:0]   cnt_q;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] arg;
  logic                 accept;
  logic                 take;
  logic                 last;
  logic [ADDR_SIZE:0]   burst_len;
  logic [ADDR_SIZE-1:0] rd_step;
  logic [ADDR_SIZE-1:0] wr_step;

  assign cmd    = din[DATA_SIZE+1:DATA_SIZE];
  assign arg    = din[ADDR_SIZE-1:0];
  assign accept = rx_valid & rx_ready;
  assign take   = (state_q == BURST) & tx_ready;
  assign last   = (cnt_q == CNT_ONE);

`ifdef RAM_SPI_AUTOINC_EN
  assign burst_len = {1'b0, arg} + CNT_ONE;
  assign rd_step   = rd_addr_q + 1'b1;
  assign wr_step   = wr_addr_q + 1'b1;
`else
  assign burst_len = CNT_ONE;
  assign rd_step   = rd_addr_q;
  assign wr_step   = wr_addr_q;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && (cmd == CMD_BURST)) begin
          state_d = BURST;
        end
      end
      BURST: begin
        tx_valid = 1'b1;
        if (tx_ready && last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory, address pointers, burst counter and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      dout      <= '0;
      cmd_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (rx_valid && !rx_ready) begin
        cmd_err <= 1'b1;
      end

      if (accept) begin
        case (cmd)
          CMD_WADDR: wr_addr_q <= arg;
          CMD_WRITE: begin
            mem[wr_addr_q] <= din[DATA_SIZE-1:0];
            wr_addr_q      <= wr_step;
          end
          CMD_RADDR: rd_addr_q <= arg;
          CMD_BURST: begin
            cnt_q <= burst_len;
            dout  <= mem[rd_addr_q];
          end
          default: ;
        endcase
      end

      // Writes cannot happen in BURST, so prefetching the next word here never
      // races a memory update.
      if (take) begin
        rd_addr_q <= rd_step;
        cnt_q     <= cnt_q - 1'b1;
        if (!last) begin
          dout <= mem[rd_step];
        end
      end
    end
  end

endmodule
